// File: rtl/reader_pie_tx.sv
// Reader-side PIE (pulse-interval encoding) transmitter.
// Sends delimiter, data-0, RTcal, optional TRcal, then the payload MSB-first.
// Every symbol is a high phase followed by a fixed-width low pulse.
//
// Request protocol: start is a one-cycle request that is only honoured while
// busy=0 (state IDLE) and abort=0. Once accepted, busy stays 1 through the
// single DONE cycle, in which done=1. Any start seen while busy=1 is dropped.
module reader_pie_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        use_preamble,
  input  logic [63:0] cmd_bits,
  input  logic [6:0]  cmd_len,
  input  logic [7:0]  tari_cycles,
  input  logic [7:0]  pw_cycles,
  input  logic [7:0]  delim_cycles,
  input  logic [9:0]  trcal_cycles,
  output logic        pie_out,
  output logic        busy,
  output logic        done,
  output logic [6:0]  bits_sent
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELIM    = 3'd1,
    S_SYM_HIGH = 3'd2,
    S_SYM_LOW  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Which symbol of the frame is currently on air.
  typedef enum logic [1:0] {
    K_DATA0   = 2'd0,
    K_RTCAL   = 2'd1,
    K_TRCAL   = 2'd2,
    K_PAYLOAD = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [9:0]  cnt_q, cnt_d;          // cycles left in the current phase, minus one
  logic [63:0] cmd_q, cmd_d;          // payload left-aligned; bit 63 is the next bit
  logic [6:0]  rem_q, rem_d;          // payload bits not yet finished
  logic [6:0]  bits_sent_q, bits_sent_d;
  logic        pre_q, pre_d;
  logic [7:0]  tari_q, tari_d;
  logic [7:0]  pw_q, pw_d;
  logic [7:0]  delim_q, delim_d;
  logic [9:0]  trcal_q, trcal_d;
  logic        pie_q, pie_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [9:0]  p_len;                 // low pulse width, at least one cycle
  logic [6:0]  len_in_eff;            // requested payload length clamped to 64
  logic        go_high;
  kind_t       nxt_kind;
  logic        nxt_bit;

  assign p_len      = (pw_q == 8'd0) ? 10'd1 : {2'b00, pw_q};
  assign len_in_eff = (cmd_len > 7'd64) ? 7'd64 : cmd_len;

  // High-phase length of a symbol: symbol length minus the low pulse, never
  // shorter than one cycle. All arithmetic is 10 bits so 3*tari cannot wrap.
  function automatic logic [9:0] high_len(input kind_t      kind,
                                          input logic       bit_val,
                                          input logic [7:0] tari,
                                          input logic [9:0] trcal,
                                          input logic [9:0] p);
    logic [9:0] t1;
    logic [9:0] t2;
    logic [9:0] sym;
    t1 = {2'b00, tari};
    t2 = {1'b0, tari, 1'b0};
    case (kind)
      K_DATA0: sym = t1;
      K_RTCAL: sym = t1 + t2;
      K_TRCAL: sym = trcal;
      default: sym = bit_val ? t2 : t1;
    endcase
    high_len = (sym > p) ? (sym - p) : 10'd1;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_DATA0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rem_q       <= '0;
      bits_sent_q <= '0;
      pre_q       <= 1'b0;
      tari_q      <= '0;
      pw_q        <= '0;
      delim_q     <= '0;
      trcal_q     <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rem_q       <= rem_d;
      bits_sent_q <= bits_sent_d;
      pre_q       <= pre_d;
      tari_q      <= tari_d;
      pw_q        <= pw_d;
      delim_q     <= delim_d;
      trcal_q     <= trcal_d;
    end
  end

  // Next-state and datapath update: phase counting and symbol sequencing.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    rem_d       = rem_q;
    bits_sent_d = bits_sent_q;
    pre_d       = pre_q;
    tari_d      = tari_q;
    pw_d        = pw_q;
    delim_d     = delim_q;
    trcal_d     = trcal_q;
    go_high     = 1'b0;
    nxt_kind    = kind_q;
    nxt_bit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_DELIM;
          pre_d       = use_preamble;
          tari_d      = tari_cycles;
          pw_d        = pw_cycles;
          delim_d     = delim_cycles;
          trcal_d     = trcal_cycles;
          kind_d      = K_DATA0;
          cmd_d       = cmd_bits << (7'd64 - len_in_eff);
          rem_d       = len_in_eff;
          bits_sent_d = '0;
          cnt_d       = (delim_cycles == 8'd0) ? 10'd0 : ({2'b00, delim_cycles} - 10'd1);
        end
      end
      S_DELIM: begin
        if (cnt_q == 10'd0) begin
          go_high  = 1'b1;
          nxt_kind = K_DATA0;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      S_SYM_HIGH: begin
        if (cnt_q == 10'd0) begin
          state_d = S_SYM_LOW;
          cnt_d   = p_len - 10'd1;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      S_SYM_LOW: begin
        if (cnt_q == 10'd0) begin
          case (kind_q)
            K_DATA0: begin
              go_high  = 1'b1;
              nxt_kind = K_RTCAL;
            end
            K_RTCAL: begin
              if (pre_q) begin
                go_high  = 1'b1;
                nxt_kind = K_TRCAL;
              end else if (rem_q != 7'd0) begin
                go_high  = 1'b1;
                nxt_kind = K_PAYLOAD;
                nxt_bit  = cmd_q[63];
              end else begin
                state_d = S_DONE;
              end
            end
            K_TRCAL: begin
              if (rem_q != 7'd0) begin
                go_high  = 1'b1;
                nxt_kind = K_PAYLOAD;
                nxt_bit  = cmd_q[63];
              end else begin
                state_d = S_DONE;
              end
            end
            default: begin
              bits_sent_d = bits_sent_q + 7'd1;
              rem_d       = rem_q - 7'd1;
              cmd_d       = {cmd_q[62:0], 1'b0};
              if (rem_q == 7'd1) begin
                state_d = S_DONE;
              end else begin
                go_high  = 1'b1;
                nxt_kind = K_PAYLOAD;
                nxt_bit  = cmd_q[62];
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_high) begin
      state_d = S_SYM_HIGH;
      kind_d  = nxt_kind;
      cnt_d   = high_len(nxt_kind, nxt_bit, tari_q, trcal_q, p_len) - 10'd1;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    pie_d  = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_IDLE:     begin pie_d = 1'b1; busy_d = 1'b0; done_d = 1'b0; end
      S_DELIM:    begin pie_d = 1'b0; busy_d = 1'b1; done_d = 1'b0; end
      S_SYM_HIGH: begin pie_d = 1'b1; busy_d = 1'b1; done_d = 1'b0; end
      S_SYM_LOW:  begin pie_d = 1'b0; busy_d = 1'b1; done_d = 1'b0; end
      S_DONE:     begin pie_d = 1'b1; busy_d = 1'b1; done_d = 1'b1; end
      default:    begin pie_d = 1'b1; busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // Output registers; reset parks the line at carrier.
  always_ff @(posedge clk) begin
    if (reset) begin
      pie_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pie_q  <= pie_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign pie_out   = pie_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_sent = bits_sent_q;

endmodule

// File: tb/tb_reader_pie_tx.sv
// Bench for reader_pie_tx: table of hand-computed frames, collision and reset
// sequences, and random frames, all checked against a waveform model built
// from symbol lengths.
module tb_reader_pie_tx;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        use_preamble;
  logic [63:0] cmd_bits;
  logic [6:0]  cmd_len;
  logic [7:0]  tari_cycles;
  logic [7:0]  pw_cycles;
  logic [7:0]  delim_cycles;
  logic [9:0]  trcal_cycles;
  logic        pie_out;
  logic        busy;
  logic        done;
  logic [6:0]  bits_sent;

  int total;
  int bad;

  typedef struct {
    logic        pre;
    logic [63:0] cmd;
    logic [6:0]  len;
    logic [7:0]  tari;
    logic [7:0]  pw;
    logic [7:0]  delim;
    logic [9:0]  trcal;
    int          exp_done;
    int          exp_bits;
  } vec_t;

  vec_t tbl[6];
  int   exp_pie[$];
  int   exp_bits_q[$];
  int   exp_n;

  reader_pie_tx dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .use_preamble (use_preamble),
    .cmd_bits     (cmd_bits),
    .cmd_len      (cmd_len),
    .tari_cycles  (tari_cycles),
    .pw_cycles    (pw_cycles),
    .delim_cycles (delim_cycles),
    .trcal_cycles (trcal_cycles),
    .pie_out      (pie_out),
    .busy         (busy),
    .done         (done),
    .bits_sent    (bits_sent)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Waveform model: list of symbol lengths, each split into high and low.
  task automatic build_model(input vec_t v);
    int p;
    int d;
    int hi;
    int first_pay;
    int nsent;
    int syms[$];
    exp_pie.delete();
    exp_bits_q.delete();
    p     = (v.pw == 0) ? 1 : int'(v.pw);
    d     = (v.delim == 0) ? 1 : int'(v.delim);
    exp_n = (v.len > 7'd64) ? 64 : int'(v.len);
    syms.push_back(int'(v.tari));
    syms.push_back(3 * int'(v.tari));
    if (v.pre) syms.push_back(int'(v.trcal));
    first_pay = syms.size();
    for (int i = exp_n - 1; i >= 0; i--)
      syms.push_back(v.cmd[i] ? 2 * int'(v.tari) : int'(v.tari));
    repeat (d) begin
      exp_pie.push_back(0);
      exp_bits_q.push_back(0);
    end
    nsent = 0;
    for (int s = 0; s < syms.size(); s++) begin
      hi = (syms[s] > p) ? syms[s] - p : 1;
      repeat (hi) begin
        exp_pie.push_back(1);
        exp_bits_q.push_back(nsent);
      end
      repeat (p) begin
        exp_pie.push_back(0);
        exp_bits_q.push_back(nsent);
      end
      if (s >= first_pay) nsent++;
    end
  endtask

  task automatic scramble_inputs();
    cmd_bits     = {$urandom, $urandom};
    cmd_len      = 7'($urandom_range(0, 127));
    tari_cycles  = 8'($urandom_range(0, 255));
    pw_cycles    = 8'($urandom_range(0, 255));
    delim_cycles = 8'($urandom_range(0, 255));
    trcal_cycles = 10'($urandom_range(0, 1023));
    use_preamble = 1'($urandom_range(0, 1));
  endtask

  // Drives a start at the current negedge and checks every following cycle.
  // check_mode: 0 = waveform only, 1 = also table done cycle/bits, 2 = expect no done.
  task automatic run_frame(input vec_t v, input int abort_at, input int reset_at,
                           input int glitch_at, input int check_mode);
    int q;
    int stop;
    int kill_at;
    int done_at;
    int bits_at;
    build_model(v);
    q       = exp_pie.size();
    kill_at = (abort_at > 0) ? abort_at : reset_at;
    stop    = (kill_at > 0) ? kill_at + 4 : q + 2;
    done_at = 0;
    bits_at = -1;
    use_preamble = v.pre;
    cmd_bits     = v.cmd;
    cmd_len      = v.len;
    tari_cycles  = v.tari;
    pw_cycles    = v.pw;
    delim_cycles = v.delim;
    trcal_cycles = v.trcal;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= stop; k++) begin
      if (kill_at > 0 && k > kill_at) begin
        check("pie_killed", int'(pie_out), 1);
        check("busy_killed", int'(busy), 0);
        check("done_killed", int'(done), 0);
        if (reset_at > 0 && k == reset_at + 1) check("bits_after_reset", int'(bits_sent), 0);
      end else if (k <= q) begin
        check("pie", int'(pie_out), exp_pie[k-1]);
        check("busy", int'(busy), 1);
        check("done_early", int'(done), 0);
        check("bits_sent", int'(bits_sent), exp_bits_q[k-1]);
      end else if (k == q + 1) begin
        check("pie_done", int'(pie_out), 1);
        check("busy_done", int'(busy), 1);
        check("done_pulse", int'(done), 1);
        check("bits_done", int'(bits_sent), exp_n);
      end else begin
        check("pie_idle", int'(pie_out), 1);
        check("busy_idle", int'(busy), 0);
        check("done_idle", int'(done), 0);
      end
      if (done && done_at == 0) begin
        done_at = k;
        bits_at = int'(bits_sent);
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      if (k == abort_at) abort = 1'b1;
      if (k == reset_at) reset = 1'b1;
      if (k == glitch_at) begin
        scramble_inputs();
        start = 1'b1;
      end
      if (k < stop) @(negedge clk);
    end
    if (check_mode == 1) begin
      check("done_cycle", done_at, v.exp_done);
      check("bits_at_done", bits_at, v.exp_bits);
    end else if (check_mode == 2) begin
      check("no_done_pulse", done_at, 0);
    end
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    scramble_inputs();

    // Frame table: {pre, cmd, len, tari, pw, delim, trcal, done cycle, bits}.
    tbl[0] = '{1'b0, 64'h2, 7'd2,   8'd4, 8'd2, 8'd3, 10'd0,  32,  2};
    tbl[1] = '{1'b1, 64'h2, 7'd2,   8'd4, 8'd2, 8'd3, 10'd20, 52,  2};
    tbl[2] = '{1'b0, 64'h0, 7'd1,   8'd1, 8'd0, 8'd0, 10'd0,  9,   1};
    tbl[3] = '{1'b0, 64'h3, 7'd0,   8'd4, 8'd2, 8'd3, 10'd0,  20,  0};
    tbl[4] = '{1'b0, 64'h0, 7'd100, 8'd2, 8'd1, 8'd2, 10'd0,  139, 64};
    tbl[5] = '{1'b1, 64'h1, 7'd1,   8'd2, 8'd5, 8'd1, 10'd3,  26,  1};

    // Reset with start and abort asserted must still land in IDLE.
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    check("reset_pie", int'(pie_out), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bits", int'(bits_sent), 0);
    @(negedge clk);

    // Table frames, back to back: each start lands in the cycle after DONE.
    for (int i = 0; i < 6; i++) run_frame(tbl[i], 0, 0, 0, 1);

    // Abort in the 3rd payload bit (cycles 32..39) with an ignored start at cycle 10.
    v = '{1'b0, 64'h16, 7'd5, 8'd4, 8'd2, 8'd3, 10'd0, 0, 0};
    run_frame(v, 34, 0, 10, 2);

    // Abort and start together in IDLE: start is dropped.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("collide_busy", int'(busy), 0);
    check("collide_pie", int'(pie_out), 1);
    @(negedge clk);
    check("collide_busy2", int'(busy), 0);

    // Reset during the RTcal low phase (cycles 18..19), then a clean frame.
    run_frame(tbl[0], 0, 18, 0, 2);
    @(negedge clk);
    run_frame(tbl[0], 0, 0, 0, 1);

    // Random frames against the model.
    for (int r = 0; r < 25; r++) begin
      v.pre   = 1'($urandom_range(0, 1));
      v.cmd   = {$urandom, $urandom};
      v.len   = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(60, 127))
                                             : 7'($urandom_range(0, 12));
      v.tari  = 8'($urandom_range(0, 6));
      v.pw    = 8'($urandom_range(0, 5));
      v.delim = 8'($urandom_range(0, 4));
      v.trcal = 10'($urandom_range(0, 30));
      v.exp_done = 0;
      v.exp_bits = 0;
      run_frame(v, 0, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
